// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial add/subtract engine built around one full adder slice
//
// Ports:
//   clk, rst_n        : rising-edge clock, synchronous active-low reset
//   start, sub        : request (taken when ready) and operation select (0 add, 1 subtract)
//   op_a, op_b        : WIDTH-bit operands, sampled with an accepted start
//   ready, busy, done : idle flag, run/done flag, one-cycle result-valid pulse
//   sum, cout, ovf    : result, final carry (subtract: 1 = no borrow), signed overflow

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // Counter must reach WIDTH-1 without wrapping.
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   a_sr_q;
  logic [WIDTH-1:0]   b_sr_q;
  logic [WIDTH-1:0]   res_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ready_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               ovf_q;

  logic               slice_sum_d;
  logic               slice_carry_d;

  full_adder u_slice (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .sum  (slice_sum_d),
    .carry(slice_carry_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
            a_sr_q  <= op_a;
            b_sr_q  <= sub ? ~op_b : op_b;
            carry_q <= sub;
            cnt_q   <= '0;
            res_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end

        S_RUN: begin
          a_sr_q  <= {1'b0, a_sr_q[WIDTH-1:1]};
          b_sr_q  <= {1'b0, b_sr_q[WIDTH-1:1]};
          res_q   <= {slice_sum_d, res_q[WIDTH-1:1]};
          carry_q <= slice_carry_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            // On the MSB step carry_q is the carry into the MSB, so the
            // overflow compare needs no separate holding register.
            sum_q   <= {slice_sum_d, res_q[WIDTH-1:1]};
            cout_q  <= slice_carry_d;
            ovf_q   <= carry_q ^ slice_carry_d;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end

        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;

endmodule

// One-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - randomized and directed bench for serial_adder_ctrl at WIDTH 8 and 4

module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst_n;

  logic       start8, sub8;
  logic [7:0] a8, b8;
  logic       ready8, busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       start4, sub4;
  logic [3:0] a4, b4;
  logic       ready4, busy4, done4, cout4, ovf4;
  logic [3:0] sum4;

  int n_checks = 0;
  int n_pass   = 0;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .op_a(a8), .op_b(b8),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .op_a(a4), .op_b(b4),
    .ready(ready4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: integer arithmetic on unsigned and signed views. Returns {ovf, cout, sum[7:0]}.
  function automatic logic [9:0] ref_model(input int w, input int a, input int b, input bit s);
    int  mask, r_u, sa, sb, rs, half;
    bit  c, o;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    r_u  = s ? (a - b) : (a + b);
    c    = s ? (a >= b) : ((a + b) > mask);
    sa   = (a >= half) ? a - (1 << w) : a;
    sb   = (b >= half) ? b - (1 << w) : b;
    rs   = s ? (sa - sb) : (sa + sb);
    o    = (rs > half - 1) || (rs < -half);
    return {o, c, 8'(r_u & mask)};
  endfunction

  task automatic wait_ready8();
    int n = 0;
    while (!ready8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ready8) begin
      n_checks++;
      $display("FAIL wait_ready8: ready=%0b after %0d cycles, required 1", ready8, n);
    end
  endtask

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic s, input string tag);
    int         done_cnt, done_at, rdy_low;
    logic [9:0] got, exp;
    wait_ready8();
    a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    done_cnt = 0; done_at = -1; rdy_low = 0; got = '0;
    for (int k = 0; k < 12; k++) begin
      if (!ready8) rdy_low++;
      if (done8) begin
        done_cnt++;
        done_at = k;
        got = {ovf8, cout8, sum8};
      end
      @(negedge clk);
    end
    exp = ref_model(8, int'(a), int'(b), s);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s result: got ovf/cout/sum=%b/%b/%h, required %b/%b/%h",
               tag, got[9], got[8], got[7:0], exp[9], exp[8], exp[7:0]);
    else n_pass++;
    n_checks++;
    if (done_cnt !== 1) $display("FAIL %s done_count: got %0d, required 1", tag, done_cnt);
    else n_pass++;
    n_checks++;
    if (done_at !== 8) $display("FAIL %s done_cycle: got %0d, required 8", tag, done_at);
    else n_pass++;
    n_checks++;
    if (rdy_low !== 9) $display("FAIL %s ready_low_cycles: got %0d, required 9", tag, rdy_low);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start8 = 0; sub8 = 0; a8 = 0; b8 = 0;
    start4 = 0; sub4 = 0; a4 = 0; b4 = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ready8, busy8, done8, sum8, cout8, ovf8} !== {3'b100, 8'h00, 2'b00})
      $display("FAIL reset8: got ready/busy/done/sum/cout/ovf=%b/%b/%b/%h/%b/%b, required 1/0/0/00/0/0",
               ready8, busy8, done8, sum8, cout8, ovf8);
    else n_pass++;
    n_checks++;
    if ({ready4, busy4, done4, sum4, cout4, ovf4} !== {3'b100, 4'h0, 2'b00})
      $display("FAIL reset4: got ready/busy/done/sum/cout/ovf=%b/%b/%b/%h/%b/%b, required 1/0/0/0/0/0",
               ready4, busy4, done4, sum4, cout4, ovf4);
    else n_pass++;
  endtask

  task automatic test_directed();
    do_op8(8'h5A, 8'h3C, 1'b0, "add_5a_3c");
    do_op8(8'hFF, 8'h01, 1'b0, "add_ff_01");
    do_op8(8'h00, 8'h00, 1'b0, "add_00_00");
    do_op8(8'h10, 8'h20, 1'b1, "sub_10_20");
    do_op8(8'h80, 8'h01, 1'b1, "sub_80_01");
    do_op8(8'h7F, 8'h00, 1'b1, "sub_7f_00");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      do_op8(8'($urandom), 8'($urandom), 1'($urandom), "random8");
  endtask

  task automatic test_back_to_back();
    logic [7:0] a1, b1, a2, b2;
    logic       s1, s2;
    int         n_done;
    int         t [2];
    logic [9:0] r [2];
    logic [9:0] exp;
    a1 = 8'($urandom); b1 = 8'($urandom); s1 = 1'($urandom);
    a2 = 8'($urandom); b2 = 8'($urandom); s2 = 1'($urandom);
    n_done = 0; t[0] = -1; t[1] = -1; r[0] = '0; r[1] = '0;
    wait_ready8();
    a8 = a1; b8 = b1; sub8 = s1; start8 = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 24; k++) begin
      if (done8) begin
        if (n_done < 2) begin
          t[n_done] = k;
          r[n_done] = {ovf8, cout8, sum8};
        end
        n_done++;
      end
      if (k == 2 || k == 3) begin
        a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
      end
      if (k == 5) begin
        a8 = a2; b8 = b2; sub8 = s2;
      end
      if (k == 11) start8 = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (n_done !== 2) $display("FAIL b2b_done_count: got %0d, required 2", n_done);
    else n_pass++;
    n_checks++;
    if (t[0] !== 8) $display("FAIL b2b_first_done_cycle: got %0d, required 8", t[0]);
    else n_pass++;
    n_checks++;
    if (t[1] - t[0] !== 10) $display("FAIL b2b_done_spacing: got %0d, required 10", t[1] - t[0]);
    else n_pass++;
    exp = ref_model(8, int'(a1), int'(b1), s1);
    n_checks++;
    if (r[0] !== exp) $display("FAIL b2b_first_result: got %h, required %h", r[0], exp);
    else n_pass++;
    exp = ref_model(8, int'(a2), int'(b2), s2);
    n_checks++;
    if (r[1] !== exp) $display("FAIL b2b_second_result: got %h, required %h", r[1], exp);
    else n_pass++;
  endtask

  task automatic test_abort();
    int n_done;
    do_op8(8'h5A, 8'h3C, 1'b0, "pre_abort");
    wait_ready8();
    a8 = 8'h11; b8 = 8'h22; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n_done = 0;
    for (int k = 0; k < 22; k++) begin
      if (k == 3) rst_n = 1'b0;
      if (k == 4) begin
        rst_n = 1'b1;
        n_checks++;
        if ({ready8, busy8, done8, sum8, cout8, ovf8} !== {3'b100, 8'h00, 2'b00})
          $display("FAIL abort_state: got ready/busy/done/sum/cout/ovf=%b/%b/%b/%h/%b/%b, required 1/0/0/00/0/0",
                   ready8, busy8, done8, sum8, cout8, ovf8);
        else n_pass++;
      end
      if (k >= 4 && done8) n_done++;
      @(negedge clk);
    end
    n_checks++;
    if (n_done !== 0) $display("FAIL abort_no_done: got %0d done pulses, required 0", n_done);
    else n_pass++;
  endtask

  task automatic test_w4_exhaustive();
    int         done_cnt, n_wait;
    logic [9:0] got, exp;
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          n_wait = 0;
          while (!ready4 && n_wait < 20) begin
            @(negedge clk);
            n_wait++;
          end
          a4 = 4'(a); b4 = 4'(b); sub4 = 1'(s); start4 = 1'b1;
          @(negedge clk);
          start4 = 1'b0;
          done_cnt = 0; got = '0;
          for (int k = 0; k < 7; k++) begin
            if (done4) begin
              done_cnt++;
              got = {ovf4, cout4, 4'h0, sum4};
            end
            @(negedge clk);
          end
          exp = ref_model(4, a, b, 1'(s));
          n_checks++;
          if (got !== exp || done_cnt !== 1)
            $display("FAIL w4 a=%h b=%h sub=%0d: got ovf/cout/sum=%b/%b/%h done_count=%0d, required %b/%b/%h done_count=1",
                     a, b, s, got[9], got[8], got[3:0], done_cnt, exp[9], exp[8], exp[3:0]);
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_abort();
    test_w4_exhaustive();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
